icache_responder: RTL and testbench
===================================

Name: icache_responder

Overview:
- Blocking, direct-mapped instruction cache. Serves the fetch stage's 2-wide request port: icache_addr/icache_re in; icache_dout/icache_dout_val/icache_stall out.
- Hit: one aligned instruction pair the cycle after the request is accepted. Miss: stalls fetch, refills the line from a beat-based memory port, then replays the lookup.

Parameters:
- CPU_ADDR_BITS, 32, address width
- CPU_INST_BITS, 32, instruction width
- FETCH_WIDTH, 2, instructions per response
- NUM_SETS, 64, lines in the cache (power of 2)
- LINE_BYTES, 32, bytes per line (power of 2, ≥ 8)
- MEM_DATA_BITS, 64, memory beat width (equals FETCH_WIDTH*CPU_INST_BITS)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- flush  in  1  pipeline flush; discards any undelivered response
- icache_addr  in  CPU_ADDR_BITS  request address; bits [2:0] ignored
- icache_re  in  1  request valid
- icache_stall  out  1  cache busy; no request accepted this cycle
- icache_dout  out  FETCH_WIDTH*CPU_INST_BITS  instruction pair; inst0 in the low 32 bits
- icache_dout_val  out  1  icache_dout valid
- mem_req_val  out  1  line refill request
- mem_req_rdy  in  1  memory accepts the request
- mem_req_addr  out  CPU_ADDR_BITS  line-aligned refill address
- mem_resp_val  in  1  refill beat valid
- mem_resp_data  in  MEM_DATA_BITS  refill beat

Behaviour:
- Address split:
  - offset = log2(LINE_BYTES) = 5 bits; pair select = addr[4:3]
  - index = addr[10:5]; tag = addr[31:11] (21 bits)
  - The tag array stores tag+valid per set; the data array stores BEATS = LINE_BYTES*8/MEM_DATA_BITS = 4 pairs per set.
- Accept rule: a request is accepted at cycle N iff icache_re && !icache_stall && rst.
  - The address is registered (req_addr, req_val = 1); the arrays are read synchronously at N.
  - Without an accepted request, req_val = 0 at N+1.
- States: LOOKUP, MISS_REQ, MISS_RESP, REPLAY.
- LOOKUP:
  - If req_val and the stored tag matches and valid: icache_dout_val = 1 and icache_dout = pair[req_addr[4:3]] (hit latency 1). Back-to-back hits give one response per cycle.
  - If req_val and miss: icache_stall = 1 combinationally in that cycle, and the FSM goes to MISS_REQ.
- MISS_REQ:
  - mem_req_val = 1; mem_req_addr = {req_addr[31:5], 5'b0}.
  - When mem_req_rdy = 1, go to MISS_RESP with beat counter = 0. mem_req_val drops the next cycle.
- MISS_RESP:
  - Each mem_resp_val writes mem_resp_data into data[index][beat], then beat++ (wraps at BEATS, 2 bits).
  - Beat k holds line bytes 8k..8k+7.
  - On the beat with beat == BEATS-1: write the tag, set valid, and go to REPLAY (or to LOOKUP if the miss was flushed).
- REPLAY:
  - Re-read the arrays at req_addr with req_val held at 1, then go to LOOKUP.
  - The next cycle hits and delivers the pair with icache_dout_val = 1.
- icache_stall: 1 in MISS_REQ, MISS_RESP and REPLAY, and in LOOKUP on a miss; 0 otherwise.
- icache_dout_val is never asserted while icache_stall = 1.
- Flush:
  - In LOOKUP: clears req_val, so icache_dout_val = 0 next cycle. A request presented in the same cycle as flush is still accepted, if not stalled.
  - During a miss: the refill runs to completion and the line is installed. There is no replay and no response; the FSM returns to LOOKUP with req_val = 0, and icache_stall stays 1 until then.
- Reset (rst = 0, any state, including mid-refill):
  - FSM to LOOKUP, req_val = 0, beat counter = 0, all valid bits cleared in one cycle.
  - Outputs: icache_stall = 0, icache_dout_val = 0, mem_req_val = 0, icache_dout = 0.
  - Memory beats arriving after reset are ignored.
- mem_resp_val outside MISS_RESP is ignored.
- Data arrays are not reset.

Test Plan:
- Reset, then request 0x1000 → cycle+1: stall = 1, dout_val = 0; mem_req_addr = 0x1000. Return 4 beats; 2 cycles after the last beat: dout_val = 1, dout = beat0. Stall is low from that cycle.
- After the 0x1000 fill, requests 0x1008, 0x1010, 0x1018 on consecutive cycles → three consecutive dout_val = 1 carrying beats 1, 2, 3. No stall.
- Conflict: 0x1000 then 0x1800 (same index 0, different tag) → second request misses and refills. A repeated 0x1000 then misses again.
- Flush asserted during MISS_RESP of 0x2000 → no dout_val after the fill. A following request to 0x2008 hits with 1-cycle latency.
- mem_req_rdy held low 5 cycles → mem_req_val and mem_req_addr stable for the whole hold. Stall held throughout.
- rst low after beat 2 of a refill → every output is at its reset value the next cycle. The 0x1000 line is invalid, so a re-request misses.

Source files
------------

// File: rtl/icache_responder.sv
// ----------------------------------------------------------------------------
// icache_responder
//
// Blocking, direct-mapped instruction cache serving a 2-wide fetch port.
// A hit returns one aligned instruction pair the cycle after the request is
// accepted. A miss stalls fetch, refills the whole line from a beat-based
// memory port, then replays the lookup so the pair is delivered as a hit.
//
// Ports:
//   clk             clock
//   rst             synchronous, active-low reset
//   flush           pipeline flush; discards any undelivered response
//   icache_addr     request address (bits [2:0] ignored)
//   icache_re       request valid
//   icache_stall    cache busy; no request accepted this cycle
//   icache_dout     instruction pair, inst0 in the low word
//   icache_dout_val icache_dout valid
//   mem_req_val     line refill request
//   mem_req_rdy     memory accepts the refill request
//   mem_req_addr    line-aligned refill address
//   mem_resp_val    refill beat valid
//   mem_resp_data   refill beat (beat k holds line bytes 8k..8k+7)
// ----------------------------------------------------------------------------
module icache_responder #(
    parameter int CPU_ADDR_BITS = 32,
    parameter int CPU_INST_BITS = 32,
    parameter int FETCH_WIDTH   = 2,
    parameter int NUM_SETS      = 64,
    parameter int LINE_BYTES    = 32,
    parameter int MEM_DATA_BITS = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [CPU_ADDR_BITS-1:0]             icache_addr,
    input  logic                                 icache_re,
    output logic                                 icache_stall,
    output logic [FETCH_WIDTH*CPU_INST_BITS-1:0] icache_dout,
    output logic                                 icache_dout_val,
    output logic                                 mem_req_val,
    input  logic                                 mem_req_rdy,
    output logic [CPU_ADDR_BITS-1:0]             mem_req_addr,
    input  logic                                 mem_resp_val,
    input  logic [MEM_DATA_BITS-1:0]             mem_resp_data
);

    localparam int OFFSET_BITS = $clog2(LINE_BYTES);
    localparam int INDEX_BITS  = $clog2(NUM_SETS);
    localparam int TAG_BITS    = CPU_ADDR_BITS - OFFSET_BITS - INDEX_BITS;
    localparam int BEATS       = LINE_BYTES * 8 / MEM_DATA_BITS;
    localparam int BEAT_BITS   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PAIR_LSB    = $clog2(MEM_DATA_BITS / 8);

    localparam logic [1:0] LOOKUP    = 2'd0;
    localparam logic [1:0] MISS_REQ  = 2'd1;
    localparam logic [1:0] MISS_RESP = 2'd2;
    localparam logic [1:0] REPLAY    = 2'd3;

    // Storage arrays; only the valid bits are cleared by reset.
    logic [TAG_BITS-1:0]      tag_q  [NUM_SETS];
    logic [MEM_DATA_BITS-1:0] data_q [NUM_SETS][BEATS];
    logic [NUM_SETS-1:0]      valid_q;

    // Synchronous read port outputs.
    logic [TAG_BITS-1:0]      rd_tag_q;
    logic                     rd_valid_q;
    logic [MEM_DATA_BITS-1:0] rd_data_q;

    logic [1:0]               state_q, state_d;
    logic                     req_val_q, req_val_d;
    logic [CPU_ADDR_BITS-1:0] req_addr_q, req_addr_d;
    logic [BEAT_BITS-1:0]     beat_q, beat_d;
    logic                     flushed_q, flushed_d;

    logic                     hit;
    logic                     accept;
    logic                     rd_en;
    logic [CPU_ADDR_BITS-1:0] rd_addr;
    logic                     fill_we;
    logic                     tag_we;
    logic                     last_beat;
    logic [INDEX_BITS-1:0]    req_index;
    logic [TAG_BITS-1:0]      req_tag;
    logic                     unused_low_bits;

    function automatic logic [BEAT_BITS-1:0] pairSel(input logic [CPU_ADDR_BITS-1:0] a);
        if (BEATS > 1) return a[PAIR_LSB +: BEAT_BITS];
        else           return '0;
    endfunction

    assign req_index = req_addr_q[OFFSET_BITS +: INDEX_BITS];
    assign req_tag   = req_addr_q[CPU_ADDR_BITS-1 -: TAG_BITS];

    assign hit = req_val_q && rd_valid_q && (rd_tag_q == req_tag);

    assign icache_stall    = (state_q != LOOKUP) || (req_val_q && !hit);
    assign icache_dout_val = (state_q == LOOKUP) && hit;
    assign icache_dout     = icache_dout_val ? rd_data_q : '0;

    assign mem_req_val  = (state_q == MISS_REQ);
    assign mem_req_addr = {req_addr_q[CPU_ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

    assign accept    = icache_re && !icache_stall && rst;
    assign last_beat = (beat_q == BEAT_BITS'(BEATS - 1));
    assign fill_we   = (state_q == MISS_RESP) && mem_resp_val && rst;
    assign tag_we    = fill_we && last_beat;

    // The replay re-reads the arrays at the held request address so the
    // freshly written line is seen on the following LOOKUP cycle.
    assign rd_en   = accept || ((state_q == REPLAY) && rst);
    assign rd_addr = accept ? icache_addr : req_addr_q;

    assign unused_low_bits = ^{icache_addr[PAIR_LSB-1:0], req_addr_q[PAIR_LSB-1:0]};

    // Array read port and refill write port.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_tag_q   <= tag_q[rd_addr[OFFSET_BITS +: INDEX_BITS]];
            rd_valid_q <= valid_q[rd_addr[OFFSET_BITS +: INDEX_BITS]];
            rd_data_q  <= data_q[rd_addr[OFFSET_BITS +: INDEX_BITS]][pairSel(rd_addr)];
        end
        if (fill_we) begin
            data_q[req_index][beat_q] <= mem_resp_data;
        end
        if (tag_we) begin
            tag_q[req_index] <= req_tag;
        end
    end

    // Next-state logic. A flush seen anywhere during a miss is remembered in
    // flushed_q so the refill still completes but the replay is skipped.
    always_comb begin
        state_d    = state_q;
        req_val_d  = req_val_q;
        req_addr_d = req_addr_q;
        beat_d     = beat_q;
        flushed_d  = flushed_q;

        case (state_q)
            LOOKUP: begin
                flushed_d = 1'b0;
                if (req_val_q && !hit) begin
                    // Miss: hold the request unless it is flushed away.
                    if (flush) begin
                        req_val_d = 1'b0;
                    end else begin
                        state_d = MISS_REQ;
                    end
                end else begin
                    req_val_d = accept;
                    if (accept) begin
                        req_addr_d = icache_addr;
                    end
                end
            end
            MISS_REQ: begin
                if (flush) flushed_d = 1'b1;
                if (mem_req_rdy) begin
                    state_d = MISS_RESP;
                    beat_d  = '0;
                end
            end
            MISS_RESP: begin
                if (flush) flushed_d = 1'b1;
                if (mem_resp_val) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        if (flushed_q || flush) begin
                            state_d   = LOOKUP;
                            req_val_d = 1'b0;
                        end else begin
                            state_d = REPLAY;
                        end
                    end
                end
            end
            default: begin
                state_d = LOOKUP;
                if (flush) req_val_d = 1'b0;
            end
        endcase
    end

    // Control state and valid bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= LOOKUP;
            req_val_q  <= 1'b0;
            req_addr_q <= '0;
            beat_q     <= '0;
            flushed_q  <= 1'b0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_val_q  <= req_val_d;
            req_addr_q <= req_addr_d;
            beat_q     <= beat_d;
            flushed_q  <= flushed_d;
            if (tag_we) begin
                valid_q[req_index] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// ----------------------------------------------------------------------------
// tb_icache_responder
//
// Directed testbench for icache_responder: cold miss and refill, sequential
// hits, set conflict, flush during refill, delayed memory grant, and reset in
// the middle of a refill. Inputs are driven on the falling edge and outputs
// are checked on the falling edge, half a cycle away from the active edge.
// ----------------------------------------------------------------------------
module tb_icache_responder;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic        icache_stall;
    logic [63:0] icache_dout;
    logic        icache_dout_val;
    logic        mem_req_val;
    logic        mem_req_rdy;
    logic [31:0] mem_req_addr;
    logic        mem_resp_val;
    logic [63:0] mem_resp_data;

    int testCount = 0;
    int failCount = 0;

    icache_responder dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .icache_addr     (icache_addr),
        .icache_re       (icache_re),
        .icache_stall    (icache_stall),
        .icache_dout     (icache_dout),
        .icache_dout_val (icache_dout_val),
        .mem_req_val     (mem_req_val),
        .mem_req_rdy     (mem_req_rdy),
        .mem_req_addr    (mem_req_addr),
        .mem_resp_val    (mem_resp_val),
        .mem_resp_data   (mem_resp_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Refill beat k of a line; salt distinguishes successive fills.
    function automatic logic [63:0] mkBeat(input logic [31:0] line, input int k, input logic [7:0] salt);
        logic [31:0] lo;
        lo = line + 32'(8 * k) + {salt, 24'h0};
        return {lo + 32'h4, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic re, input logic [31:0] addr, input logic fl);
        icache_re   = re;
        icache_addr = addr;
        flush       = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Full miss sequence: request, optional grant delay, four beats, then
    // either a replayed hit or (when flushed mid-refill) no response.
    task automatic doMiss(input logic [31:0] addr, input logic [7:0] salt,
                          input int holdCycles, input logic doFlush);
        logic [31:0] line;
        logic [1:0]  sel;
        line = addr & 32'hFFFF_FFE0;
        sel  = addr[4:3];

        applyStimulus(1'b1, addr, 1'b0);
        tick();
        checkOutput("missStall", 64'(icache_stall), 64'(1));
        checkOutput("missNoVal", 64'(icache_dout_val), 64'(0));
        applyStimulus(1'b0, addr, 1'b0);
        tick();

        for (int i = 0; i < holdCycles; i++) begin
            checkOutput("holdReqVal", 64'(mem_req_val), 64'(1));
            checkOutput("holdReqAddr", 64'(mem_req_addr), 64'(line));
            checkOutput("holdStall", 64'(icache_stall), 64'(1));
            tick();
        end

        checkOutput("reqVal", 64'(mem_req_val), 64'(1));
        checkOutput("reqAddr", 64'(mem_req_addr), 64'(line));
        mem_req_rdy = 1'b1;
        tick();
        mem_req_rdy = 1'b0;
        checkOutput("reqValDrop", 64'(mem_req_val), 64'(0));

        for (int k = 0; k < 4; k++) begin
            mem_resp_val  = 1'b1;
            mem_resp_data = mkBeat(line, k, salt);
            flush         = doFlush && (k == 1);
            checkOutput("fillStall", 64'(icache_stall), 64'(1));
            tick();
        end
        mem_resp_val  = 1'b0;
        mem_resp_data = '0;
        flush         = 1'b0;

        if (!doFlush) begin
            checkOutput("replayStall", 64'(icache_stall), 64'(1));
            checkOutput("replayNoVal", 64'(icache_dout_val), 64'(0));
            tick();
            checkOutput("replayHitVal", 64'(icache_dout_val), 64'(1));
            checkOutput("replayHitData", icache_dout, mkBeat(line, int'(sel), salt));
            checkOutput("replayNoStall", 64'(icache_stall), 64'(0));
        end else begin
            checkOutput("flushNoStall", 64'(icache_stall), 64'(0));
            checkOutput("flushNoVal", 64'(icache_dout_val), 64'(0));
            tick();
            checkOutput("flushNoVal2", 64'(icache_dout_val), 64'(0));
        end
    endtask

    initial begin
        rst           = 1'b0;
        mem_req_rdy   = 1'b0;
        mem_resp_val  = 1'b0;
        mem_resp_data = '0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        tick();
        tick();

        // Reset state.
        checkOutput("rstStall", 64'(icache_stall), 64'(0));
        checkOutput("rstDoutVal", 64'(icache_dout_val), 64'(0));
        checkOutput("rstReqVal", 64'(mem_req_val), 64'(0));
        checkOutput("rstDout", icache_dout, 64'(0));
        rst = 1'b1;
        tick();

        // Cold miss on 0x1000, delivered as beat0.
        doMiss(32'h0000_1000, 8'h00, 0, 1'b0);

        // Back-to-back hits on the rest of the line.
        applyStimulus(1'b1, 32'h0000_1008, 1'b0);
        tick();
        checkOutput("seqHit1Val", 64'(icache_dout_val), 64'(1));
        checkOutput("seqHit1Data", icache_dout, mkBeat(32'h1000, 1, 8'h00));
        checkOutput("seqHit1Stall", 64'(icache_stall), 64'(0));
        applyStimulus(1'b1, 32'h0000_1010, 1'b0);
        tick();
        checkOutput("seqHit2Val", 64'(icache_dout_val), 64'(1));
        checkOutput("seqHit2Data", icache_dout, mkBeat(32'h1000, 2, 8'h00));
        applyStimulus(1'b1, 32'h0000_1018, 1'b0);
        tick();
        checkOutput("seqHit3Val", 64'(icache_dout_val), 64'(1));
        checkOutput("seqHit3Data", icache_dout, mkBeat(32'h1000, 3, 8'h00));
        checkOutput("seqHit3Stall", 64'(icache_stall), 64'(0));
        applyStimulus(1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("seqIdleVal", 64'(icache_dout_val), 64'(0));

        // Conflict: 0x1000 hits, 0x1800 evicts it, 0x1000 misses again.
        applyStimulus(1'b1, 32'h0000_1000, 1'b0);
        tick();
        checkOutput("preConflictHit", 64'(icache_dout_val), 64'(1));
        checkOutput("preConflictData", icache_dout, mkBeat(32'h1000, 0, 8'h00));
        applyStimulus(1'b0, 32'h0, 1'b0);
        tick();
        doMiss(32'h0000_1800, 8'h01, 0, 1'b0);
        doMiss(32'h0000_1000, 8'h02, 0, 1'b0);

        // Flush during refill of 0x2000, then 0x2008 hits.
        doMiss(32'h0000_2000, 8'h03, 0, 1'b1);
        applyStimulus(1'b1, 32'h0000_2008, 1'b0);
        tick();
        checkOutput("postFlushHitVal", 64'(icache_dout_val), 64'(1));
        checkOutput("postFlushHitData", icache_dout, mkBeat(32'h2000, 1, 8'h03));
        applyStimulus(1'b0, 32'h0, 1'b0);
        tick();

        // Memory grant withheld for five cycles.
        doMiss(32'h0000_3010, 8'h07, 5, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        tick();

        // Reset after three beats of a refill of 0x1040.
        applyStimulus(1'b1, 32'h0000_1040, 1'b0);
        tick();
        checkOutput("midMissStall", 64'(icache_stall), 64'(1));
        applyStimulus(1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("midReqAddr", 64'(mem_req_addr), 64'(32'h1040));
        mem_req_rdy = 1'b1;
        tick();
        mem_req_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_resp_val  = 1'b1;
            mem_resp_data = mkBeat(32'h1040, k, 8'h09);
            tick();
        end
        mem_resp_val = 1'b0;
        rst          = 1'b0;
        tick();
        checkOutput("midRstStall", 64'(icache_stall), 64'(0));
        checkOutput("midRstDoutVal", 64'(icache_dout_val), 64'(0));
        checkOutput("midRstReqVal", 64'(mem_req_val), 64'(0));
        checkOutput("midRstDout", icache_dout, 64'(0));
        rst = 1'b1;

        // A stray beat after reset must be ignored.
        mem_resp_val  = 1'b1;
        mem_resp_data = mkBeat(32'h1040, 3, 8'h09);
        tick();
        mem_resp_val  = 1'b0;
        checkOutput("strayStall", 64'(icache_stall), 64'(0));
        checkOutput("strayReqVal", 64'(mem_req_val), 64'(0));

        // Lines valid before reset now miss.
        doMiss(32'h0000_3008, 8'h05, 0, 1'b0);
        doMiss(32'h0000_1000, 8'h06, 0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
